// File: rtl/encoder_pkg.sv
// encoder_pkg: shared format codes, FSM states and immediate range widths.
package encoder_pkg;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam int IMM_RANGE = 12;
  localparam int JAL_RANGE = 20;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FULL} state_t;
endpackage

// File: rtl/instruction_packer.sv
// instruction_packer: packs fields and a signed immediate into an RV32I word and flags range legality.
module instruction_packer
  import encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  logic fits_12, fits_20;
  logic [31:0] i_word, s_word, b_word, j_word;
  assign fits_12 = imm == {{(32-IMM_RANGE){imm[IMM_RANGE-1]}}, imm[IMM_RANGE-1:0]};
  assign fits_20 = imm == {{(32-JAL_RANGE){imm[JAL_RANGE-1]}}, imm[JAL_RANGE-1:0]};
  assign legal = !fmt[2] && (fmt == IMM_J ? fits_20 : fits_12);
  assign i_word = {imm[11:0], rs1, funct3, rd, opcode};
  assign s_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  // B and J immediates are in halfwords, so bit k here lands where the decoder expects byte bit k+1
  assign b_word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
  assign j_word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
  assign word = fmt[1] ? (fmt[0] ? j_word : b_word) : (fmt[0] ? s_word : i_word);
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: assembles packed instructions and writes them to consecutive memory words.
module instruction_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            ImGenControl,
  input  logic [6:0]            Opcode,
  input  logic [4:0]            Rd,
  input  logic [4:0]            Rs1,
  input  logic [4:0]            Rs2,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           Immediate,
  output logic                  MemWrite,
  input  logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  RangeError,
  output logic [7:0]            ErrorCount,
  output logic [ADDR_WIDTH:0]   WordCount,
  output logic                  Full
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0] word;
  logic legal, accept, done;
  instruction_packer u_packer (
    .fmt(ImGenControl), .opcode(Opcode), .rd(Rd), .rs1(Rs1), .rs2(Rs2),
    .funct3(Funct3), .imm(Immediate), .word(word), .legal(legal)
  );
  assign InReady = state == RUN && !Start && (!MemWrite || MemReady);
  assign accept = InValid && InReady;
  assign done = MemWrite && MemReady;
  assign Full = state == FULL;
  // Start restarts the session but leaves an in-flight write to finish at its own address
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      next_addr <= BASE;
      MemWrite <= 1'b0;
      MemAddress <= '0;
      MemWriteData <= '0;
      RangeError <= 1'b0;
      ErrorCount <= '0;
      WordCount <= '0;
    end else begin
      RangeError <= accept && !legal;
      if (accept && legal) begin
        MemWrite <= 1'b1;
        MemAddress <= next_addr;
        MemWriteData <= word;
      end else if (done) MemWrite <= 1'b0;
      if (Start) begin
        state <= RUN;
        next_addr <= BASE;
        WordCount <= '0;
        ErrorCount <= '0;
      end else begin
        if (done) WordCount <= WordCount + 1'b1;
        if (accept && !legal && ErrorCount != 8'hFF) ErrorCount <= ErrorCount + 1'b1;
        if (accept && legal) begin
          if (next_addr == LAST) state <= DRAIN;
          else next_addr <= next_addr + 1'b1;
        end
        if (state == DRAIN && done) state <= FULL;
      end
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: vector table, directed corner cases and a random round trip through an immediate decoder.
module tb_instruction_encoder;
  logic Clock = 0, Reset = 1, Start = 0, InValid = 0, MemReady = 0;
  logic [2:0] ImGenControl = 0, Funct3 = 0;
  logic [6:0] Opcode = 0;
  logic [4:0] Rd = 0, Rs1 = 0, Rs2 = 0;
  logic [31:0] Immediate = 0;
  logic InReady, MemWrite, RangeError, Full;
  logic [7:0] MemAddress, ErrorCount;
  logic [8:0] WordCount;
  logic [31:0] MemWriteData;
  int tests = 0, fails = 0;

  typedef struct {logic [2:0] f; logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [31:0] imm;} ent_t;
  typedef struct {ent_t e; logic err; logic [31:0] word;} vec_t;

  instruction_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .ImGenControl(ImGenControl), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Funct3(Funct3), .Immediate(Immediate), .MemWrite(MemWrite), .MemReady(MemReady),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .RangeError(RangeError),
    .ErrorCount(ErrorCount), .WordCount(WordCount), .Full(Full)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal_ref(input ent_t e);
    int s = $signed(e.imm);
    int lim = (e.f == 3'd3) ? (1 << 19) : (1 << 11);
    return e.f < 3'd4 && s >= -lim && s < lim;
  endfunction

  // Immediate generator: byte offsets for branches/jumps are halved back to halfword units
  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
    logic [31:0] b;
    case (f)
      3'd0: b = {{20{w[31]}}, w[31:20]};
      3'd1: b = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: b = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
    if (f[1]) b = {b[31], b[31:1]};
    return b;
  endfunction

  function automatic bit word_ok(input ent_t e, input logic [31:0] w);
    bit ok = w[6:0] == e.op && dec_imm(e.f, w) == e.imm;
    if (e.f == 3'd0 || e.f == 3'd3) ok = ok && w[11:7] == e.rd;
    if (e.f != 3'd3) ok = ok && w[19:15] == e.rs1 && w[14:12] == e.f3;
    if (e.f == 3'd1 || e.f == 3'd2) ok = ok && w[24:20] == e.rs2;
    return ok;
  endfunction

  // Reference model: session phase flags, one pending-write slot and plain counters
  bit m_run, m_drain, m_full, m_pend, m_errp;
  int m_next, m_words, m_errs, m_addr, legal_acc;
  ent_t m_ent;

  always @(negedge Clock) begin : mon
    bit rdy, acc, done;
    ent_t cur;
    if (Reset) begin
      m_run = 0; m_drain = 0; m_full = 0; m_pend = 0; m_errp = 0;
      m_next = 0; m_words = 0; m_errs = 0;
    end else begin
      cur = '{ImGenControl, Opcode, Rd, Rs1, Rs2, Funct3, Immediate};
      rdy = m_run && !Start && (!m_pend || MemReady);
      chk("InReady", InReady, rdy);
      chk("MemWrite", MemWrite, m_pend);
      if (m_pend) begin
        chk("MemAddress", MemAddress, m_addr);
        tests++;
        if (!word_ok(m_ent, MemWriteData)) begin
          fails++;
          $display("FAIL decode: got word %h, expected fmt %0d imm %h op %h", MemWriteData, m_ent.f, m_ent.imm, m_ent.op);
        end
      end
      chk("RangeError", RangeError, m_errp);
      chk("ErrorCount", ErrorCount, m_errs);
      chk("WordCount", WordCount, m_words);
      chk("Full", Full, m_full);
      acc = rdy && InValid;
      done = m_pend && MemReady;
      m_errp = 0;
      if (done) begin
        m_pend = 0;
        m_words++;
        if (m_drain) begin m_drain = 0; m_full = 1; end
      end
      if (Start) begin
        m_run = 1; m_drain = 0; m_full = 0;
        m_next = 0; m_words = 0; m_errs = 0;
      end
      if (acc && legal_ref(cur)) begin
        m_pend = 1; m_addr = m_next; m_ent = cur; legal_acc++;
        if (m_next == 255) begin m_run = 0; m_drain = 1; end
        else m_next++;
      end else if (acc) begin
        m_errp = 1;
        if (m_errs < 255) m_errs++;
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic drive(input ent_t e);
    ImGenControl = e.f; Opcode = e.op; Rd = e.rd; Rs1 = e.rs1; Rs2 = e.rs2; Funct3 = e.f3; Immediate = e.imm;
  endtask

  task automatic send(input ent_t e);
    bit ok = 0;
    drive(e);
    InValid = 1;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1 ok = InReady;
      if (!ok) tick();
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got InReady 0 expected 1");
    end else tick();
    InValid = 0;
  endtask

  task automatic start_session();
    Start = 1;
    tick();
    Start = 0;
  endtask

  vec_t vt[9];
  ent_t e;

  initial begin
    int addr = 0, errs = 0, lim;
    vt[0] = '{'{3'd0, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 32'hFFFFFFFC}, 1'b0, 32'hFFC12283};
    vt[1] = '{'{3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0007FFFF}, 1'b0, 32'h7FFFF0EF};
    vt[2] = '{'{3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00080000}, 1'b1, 32'h0};
    vt[3] = '{'{3'd1, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 32'h00000008}, 1'b0, 32'h00512423};
    vt[4] = '{'{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFE}, 1'b0, 32'hFE208EE3};
    vt[5] = '{'{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800}, 1'b1, 32'h0};
    vt[6] = '{'{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFF800}, 1'b0, 32'h80000093};
    vt[7] = '{'{3'd4, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000001}, 1'b1, 32'h0};
    vt[8] = '{'{3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF}, 1'b0, 32'hFE000FA3};

    repeat (2) @(posedge Clock);
    #2;
    chk("rst_InReady", InReady, 0); chk("rst_MemWrite", MemWrite, 0);
    chk("rst_MemAddress", MemAddress, 0); chk("rst_MemWriteData", MemWriteData, 0);
    chk("rst_RangeError", RangeError, 0); chk("rst_ErrorCount", ErrorCount, 0);
    chk("rst_WordCount", WordCount, 0); chk("rst_Full", Full, 0);
    Reset = 0;
    tick();
    #1 chk("idle_InReady", InReady, 0);

    start_session();
    MemReady = 1;
    foreach (vt[i]) begin
      send(vt[i].e);
      #1;
      if (vt[i].err) begin
        errs++;
        chk("vec_RangeError", RangeError, 1);
        chk("vec_ErrorCount", ErrorCount, errs);
      end else begin
        chk("vec_data", MemWriteData, vt[i].word);
        chk("vec_addr", MemAddress, addr);
        addr++;
      end
    end
    tick();
    #1 chk("vec_WordCount", WordCount, addr);

    // Backpressure: pending write must hold while the next entry waits
    tick();
    start_session();
    MemReady = 0;
    send(vt[0].e);
    drive(vt[3].e);
    InValid = 1;
    repeat (3) begin
      #1;
      chk("bp_InReady", InReady, 0); chk("bp_MemWrite", MemWrite, 1);
      chk("bp_addr", MemAddress, 0); chk("bp_data", MemWriteData, vt[0].word);
      tick();
    end
    MemReady = 1;
    #1 chk("bp_ready_rise", InReady, 1);
    tick();
    InValid = 0;
    #1;
    chk("bp_next_MemWrite", MemWrite, 1); chk("bp_next_addr", MemAddress, 1);
    chk("bp_next_data", MemWriteData, vt[3].word); chk("bp_WordCount", WordCount, 1);
    tick();

    // Start priority over an accept while a write is pending
    start_session();
    MemReady = 1;
    send(vt[6].e);
    MemReady = 0;
    drive(vt[8].e);
    Start = 1; InValid = 1;
    #1 chk("sp_InReady", InReady, 0);
    tick();
    Start = 0; InValid = 0;
    #1;
    chk("sp_MemWrite", MemWrite, 1); chk("sp_old_addr", MemAddress, 0);
    chk("sp_old_data", MemWriteData, vt[6].word); chk("sp_WordCount", WordCount, 0);
    tick();
    MemReady = 1;
    tick();
    #1 chk("sp_done_MemWrite", MemWrite, 0);
    chk("sp_done_WordCount", WordCount, 1);
    send(vt[8].e);
    #1 chk("sp_base_addr", MemAddress, 0);
    tick();

    // Fill the whole address space, then restart
    start_session();
    MemReady = 1;
    for (int i = 0; i < 256; i++) send('{3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'(i)});
    #1;
    chk("fill_last_addr", MemAddress, 255); chk("fill_drain_InReady", InReady, 0);
    chk("fill_drain_Full", Full, 0); chk("fill_drain_MemWrite", MemWrite, 1);
    tick();
    #1;
    chk("fill_Full", Full, 1); chk("fill_WordCount", WordCount, 256);
    chk("fill_InReady", InReady, 0); chk("fill_MemWrite", MemWrite, 0);
    start_session();
    send(vt[0].e);
    #1 chk("fill_restart_addr", MemAddress, 0);
    tick();

    // ErrorCount saturation
    start_session();
    for (int i = 0; i < 260; i++) send(vt[7].e);
    #1 chk("sat_ErrorCount", ErrorCount, 255);
    chk("sat_RangeError", RangeError, 1);
    tick();

    // Random round trip
    legal_acc = 0;
    for (int c = 0; c < 40000 && legal_acc < 10000; c++) begin
      Start = m_full || (!m_run && !m_drain) || $urandom_range(0, 499) == 0;
      MemReady = $urandom_range(0, 3) != 0;
      InValid = $urandom_range(0, 7) != 0;
      e.f = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      e.op = 7'($urandom); e.rd = 5'($urandom); e.rs1 = 5'($urandom); e.rs2 = 5'($urandom); e.f3 = 3'($urandom);
      lim = (e.f == 3'd3) ? (1 << 19) : (1 << 11);
      e.imm = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 2 * lim - 1) - lim;
      drive(e);
      tick();
    end
    Start = 0; InValid = 0; MemReady = 1;
    chk("rand_legal_accepts", legal_acc >= 10000, 1);
    tick();

    // Asynchronous reset in the middle of a stalled write
    start_session();
    MemReady = 0;
    send(vt[1].e);
    #2 Reset = 1;
    #1;
    chk("arst_MemWrite", MemWrite, 0); chk("arst_MemAddress", MemAddress, 0);
    chk("arst_MemWriteData", MemWriteData, 0); chk("arst_InReady", InReady, 0);
    tick();
    Reset = 0;
    #1 chk("arst_idle_InReady", InReady, 0);
    chk("arst_WordCount", WordCount, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
